mips_alu_adders: RTL and testbench



---
 rtl/mips_alu_adders.sv | 85 ++++++++
 tb/tb_mips_alu_adders.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_adders.sv
// MIPS execute-stage arithmetic: PC+4 incrementer, branch-target adder
// and main ALU with zero/overflow detect, plus a debug snapshot register.
module mips_alu_adders #(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] plus4_in,
  output logic [WIDTH-1:0] plus4_sum,
  input  logic [WIDTH-1:0] add_data1,
  input  logic [WIDTH-1:0] add_data2,
  output logic [WIDTH-1:0] add_sum,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_result,
  output logic             is_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] alu_result_q,
  output logic             is_zero_q
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic             add_ovf;
  logic             sub_ovf;

  assign plus4_sum = plus4_in + WIDTH'(PC_INC);
  assign add_sum   = add_data1 + add_data2;

  assign sum  = read_data_1 + read_data_2;
  assign diff = read_data_1 - read_data_2;

  // Direct signed compare, so SLT stays right when A - B overflows.
  assign slt = $signed(read_data_1) < $signed(read_data_2);

  assign add_ovf = (read_data_1[MSB] == read_data_2[MSB])
                 && (sum[MSB] != read_data_1[MSB]);
  assign sub_ovf = (read_data_1[MSB] != read_data_2[MSB])
                 && (diff[MSB] != read_data_1[MSB]);

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (alu_control)
      OP_AND: alu_result = read_data_1 & read_data_2;
      OP_OR:  alu_result = read_data_1 | read_data_2;
      OP_ADD: begin
        alu_result = sum;
        overflow   = add_ovf;
      end
      OP_SUB: begin
        alu_result = diff;
        overflow   = sub_ovf;
      end
      OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR: alu_result = ~(read_data_1 | read_data_2);
      default: alu_result = '0;
    endcase
  end

  assign is_zero = (alu_result == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_result_q <= '0;
      is_zero_q    <= 1'b1;
    end else begin
      alu_result_q <= alu_result;
      is_zero_q    <= is_zero;
    end
  end

endmodule

// File: tb/tb_mips_alu_adders.sv
// Scoreboard bench for mips_alu_adders: directed vectors queue their
// expected outputs, a negedge monitor pops and compares.
module tb_mips_alu_adders;

  logic        clock;
  logic        reset;
  logic [31:0] plus4_in;
  logic [31:0] plus4_sum;
  logic [31:0] add_data1;
  logic [31:0] add_data2;
  logic [31:0] add_sum;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        is_zero;
  logic        overflow;
  logic [31:0] alu_result_q;
  logic        is_zero_q;

  mips_alu_adders #(.WIDTH(32), .PC_INC(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .plus4_in     (plus4_in),
    .plus4_sum    (plus4_sum),
    .add_data1    (add_data1),
    .add_data2    (add_data2),
    .add_sum      (add_sum),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .is_zero      (is_zero),
    .overflow     (overflow),
    .alu_result_q (alu_result_q),
    .is_zero_q    (is_zero_q)
  );

  typedef struct {
    string       tag;
    logic [31:0] p4;
    logic [31:0] sum;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] res_q;
    logic        z_q;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", tag, fld, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "plus4_sum", plus4_sum, e.p4);
        chk(e.tag, "add_sum", add_sum, e.sum);
        chk(e.tag, "alu_result", alu_result, e.res);
        chk(e.tag, "is_zero", {31'd0, is_zero}, {31'd0, e.z});
        chk(e.tag, "overflow", {31'd0, overflow}, {31'd0, e.ov});
        chk(e.tag, "alu_result_q", alu_result_q, e.res_q);
        chk(e.tag, "is_zero_q", {31'd0, is_zero_q}, {31'd0, e.z_q});
      end
    end
  end

  task automatic drive(
    input string       tag,
    input logic        rst,
    input logic [31:0] pc,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  ctl,
    input logic [31:0] e_p4,
    input logic [31:0] e_sum,
    input logic [31:0] e_res,
    input logic        e_z,
    input logic        e_ov,
    input logic [31:0] e_q,
    input logic        e_zq
  );
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    plus4_in    = pc;
    add_data1   = d1;
    add_data2   = d2;
    read_data_1 = a;
    read_data_2 = b;
    alu_control = ctl;
    e.tag   = tag;
    e.p4    = e_p4;
    e.sum   = e_sum;
    e.res   = e_res;
    e.z     = e_z;
    e.ov    = e_ov;
    e.res_q = e_q;
    e.z_q   = e_zq;
    exp_q.push_back(e);
  endtask

  initial begin
    reset       = 1'b0;
    plus4_in    = '0;
    add_data1   = '0;
    add_data2   = '0;
    read_data_1 = '0;
    read_data_2 = '0;
    alu_control = '0;

    drive("add_ovf_rst", 1'b0, 32'h0, 32'h8, 32'hFFFF_FFF0,
          32'h7FFF_FFFF, 32'h1, 4'b0010,
          32'h4, 32'hFFFF_FFF8, 32'h8000_0000, 1'b0, 1'b1,
          32'h0, 1'b1);
    drive("sub_zero_rst", 1'b0, 32'hFFFF_FFFC, 32'h10, 32'h20,
          32'h5, 32'h5, 4'b0110,
          32'h0, 32'h30, 32'h0, 1'b1, 1'b0,
          32'h0, 1'b1);
    drive("add_release", 1'b1, 32'h0040_0000, 32'h100, 32'h4,
          32'h3, 32'h4, 4'b0010,
          32'h0040_0004, 32'h104, 32'h7, 1'b0, 1'b0,
          32'h0, 1'b1);
    drive("and", 1'b1, 32'h0, 32'h0, 32'h0,
          32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000,
          32'h4, 32'h0, 32'h00F0_00F0, 1'b0, 1'b0,
          32'h7, 1'b0);
    drive("or", 1'b1, 32'h0, 32'h0, 32'h0,
          32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001,
          32'h4, 32'h0, 32'hFFF0_FFF0, 1'b0, 1'b0,
          32'h00F0_00F0, 1'b0);
    drive("nor", 1'b1, 32'h0, 32'h0, 32'h0,
          32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1100,
          32'h4, 32'h0, 32'h000F_000F, 1'b0, 1'b0,
          32'hFFF0_FFF0, 1'b0);
    drive("slt_true", 1'b1, 32'h0, 32'h0, 32'h0,
          32'hFFFF_FFFF, 32'h1, 4'b0111,
          32'h4, 32'h0, 32'h1, 1'b0, 1'b0,
          32'h000F_000F, 1'b0);
    drive("slt_false", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h1, 32'hFFFF_FFFF, 4'b0111,
          32'h4, 32'h0, 32'h0, 1'b1, 1'b0,
          32'h1, 1'b0);
    drive("undef", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h1234, 32'h5678, 4'b1111,
          32'h4, 32'h0, 32'h0, 1'b1, 1'b0,
          32'h0, 1'b1);
    drive("sub_ovf", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h8000_0000, 32'h1, 4'b0110,
          32'h4, 32'h0, 32'h7FFF_FFFF, 1'b0, 1'b1,
          32'h0, 1'b1);
    drive("slt_ovf", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h8000_0000, 32'h7FFF_FFFF, 4'b0111,
          32'h4, 32'h0, 32'h1, 1'b0, 1'b0,
          32'h7FFF_FFFF, 1'b0);
    drive("add_small", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h3, 32'h4, 4'b0010,
          32'h4, 32'h0, 32'h7, 1'b0, 1'b0,
          32'h1, 1'b0);
    drive("rst_midcyc", 1'b0, 32'h0, 32'h0, 32'h0,
          32'h3, 32'h4, 4'b0010,
          32'h4, 32'h0, 32'h7, 1'b0, 1'b0,
          32'h0, 1'b1);
    drive("release2", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h0, 32'h0, 4'b0000,
          32'h4, 32'h0, 32'h0, 1'b1, 1'b0,
          32'h0, 1'b1);
    drive("add_neg_ovf", 1'b1, 32'h0, 32'h0, 32'h0,
          32'h8000_0000, 32'h8000_0000, 4'b0010,
          32'h4, 32'h0, 32'h0, 1'b1, 1'b1,
          32'h0, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clock);
    @(posedge clock);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
